nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs one wide add or subtract (4*NIBBLES bits) by time-sharing a single 4-bit adder slice, one nibble per clock, least significant nibble first.
- Carry is kept in a register between nibble steps.
- Sits between a requesting datapath (start/done handshake) and the 4-bit adder slice. Trades latency for area against a full-width adder.

Parameters:
- NIBBLES, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high while a nibble sequence is in progress (RUN).
- done  output  1  one-cycle pulse: result valid and newly updated.
- sum  output  W  registered result; held stable from done until the next completion.
- c_out  output  1  carry out of MSB nibble; in sub mode, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed two's-complement overflow of the completed operation.

Behaviour:
- Reset (async, immediate): state = IDLE; busy = 0, done = 0, sum = 0, c_out = 0, overflow = 0; index, carry and working registers cleared.
- States: IDLE, RUN, DONE.
- IDLE with start = 1 → RUN:
  - latch a into op_a;
  - latch b into op_b (bitwise-inverted if sub = 1);
  - carry <= sub; index <= 0.
- IDLE with start = 0: stay in IDLE.
- RUN, each cycle:
  - slice inputs: op_a[4*index+:4], op_b[4*index+:4], carry;
  - slice sum nibble is written into work[4*index+:4];
  - carry <= slice carry out;
  - index <= index + 1.
- RUN transition: when index == NIBBLES-1, the same edge also:
  - copies the completed work into sum;
  - sets c_out = slice carry out;
  - sets overflow = carry into MSB ^ carry out of MSB (computed from the MSB nibble's bit-2 carry, or equivalently the sign rule on op_a[W-1], op_b[W-1], sum[W-1]);
  - moves to DONE.
- DONE lasts one cycle:
  - done = 1, busy = 0;
  - start = 1 → RUN (back-to-back accept, same latch actions as IDLE);
  - otherwise → IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+NIBBLES; throughput is one operation per NIBBLES+1 cycles.
- start asserted during RUN is ignored (not queued); a, b and sub may change freely during RUN.
- sum, c_out and overflow change only on the completing edge (or reset); intermediate nibbles are never visible on sum.
- NIBBLES = 1: RUN lasts a single cycle; index never increments.
- index width = clog2(NIBBLES) (minimum 1); no wrap beyond NIBBLES-1.
- Reset asserted mid-RUN: operation is abandoned, no done pulse, and outputs return to their reset values.
- busy = (state == RUN); done = (state == DONE). Both are decoded from registered state with no combinational path from start.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  - the NIBBLE_W = 4 constant.
- One sub-module: the existing Adder4BitDataflow slice (a[3:0], b[3:0], c_in → s[3:0], c_out), instantiated once.
- The overflow carry into the MSB is derived locally as s[3] ^ a[3] ^ b[3] of the final nibble.

Test Plan:
- Reset mid-operation, then add, NIBBLES = 4:
  - assert rst for 2 cycles mid-RUN → busy = 0, done = 0, sum = 0, no done pulse;
  - release rst, then start with a = 16'h1234, b = 16'h4321, sub = 0 → busy high for 4 cycles, done pulses once on the 5th cycle after start, sum = 16'h5555, c_out = 0, overflow = 0.
- Carry ripple across all nibbles: a = 16'hFFFF, b = 16'h0001, sub = 0 → sum = 16'h0000, c_out = 1, overflow = 0.
- Subtract with borrow: a = 16'h0005, b = 16'h0007, sub = 1 → sum = 16'hFFFE, c_out = 0.
- Subtract without borrow: a = 16'h0009, b = 16'h0002, sub = 1 → sum = 16'h0007, c_out = 1.
- Signed overflow: a = 16'h7FFF, b = 16'h0001, sub = 0 → sum = 16'h8000, overflow = 1, c_out = 0.
- Handshake rules:
  - start pulsed during RUN with different operands → ignored; first result unchanged.
  - start held high through DONE → second operation begins the cycle after done, with no IDLE cycle.
  - sum stays stable throughout the second RUN until its own done.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
// Holds the FSM state encoding and the slice width.
// Imported by the sequencer top.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// Purpose: 4-bit ripple adder slice, dataflow style.
// Latency: purely combinational.
// Backpressure: none; the sequencer feeds it one nibble per cycle.
// Ports: a, b, c_in in; s (4-bit sum), c_out out.
module Adder4BitDataflow (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Purpose: wide add/sub (4*NIBBLES bits) time-sharing one 4-bit slice, LS nibble first.
// Latency: start sampled at edge k -> done high in the cycle after edge k+NIBBLES.
// Backpressure: start honoured only in IDLE/DONE; start during RUN is dropped, not queued.
// Ports: clk, rst (async, active high); start/sub/a/b request in;
//        busy, done (1-cycle pulse), sum, c_out (1 = no borrow when subtracting), overflow out.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        c_out,
    output logic                        overflow
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   index;
    logic               carry;
    logic [W-1:0]       op_a, op_b, work;

    logic [3:0]         nib_a, nib_b, nib_s;
    logic               nib_c;
    logic [W-1:0]       work_nx;
    logic               accept, last;

    assign nib_a = op_a[NIBBLE_W*index +: NIBBLE_W];
    assign nib_b = op_b[NIBBLE_W*index +: NIBBLE_W];

    Adder4BitDataflow u_slice (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry),
        .s     (nib_s),
        .c_out (nib_c)
    );

    // Work with the current nibble merged in, so the completing edge can
    // publish the full result without a partial-width concatenation.
    always_comb begin
        work_nx = work;
        work_nx[NIBBLE_W*index +: NIBBLE_W] = nib_s;
    end

    assign last   = (index == LAST_IDX);
    assign accept = start && (state == S_IDLE || state == S_DONE);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = start ? S_RUN : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index    <= '0;
            carry    <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            work     <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            index <= '0;
        end else if (state == S_RUN) begin
            work  <= work_nx;
            carry <= nib_c;
            if (last) begin
                sum      <= work_nx;
                c_out    <= nib_c;
                // Carry into bit 3 of the top nibble recovered from its sum bit.
                overflow <= (nib_s[3] ^ nib_a[3] ^ nib_b[3]) ^ nib_c;
            end else begin
                index <= index + IDX_ONE;
            end
        end
    end

endmodule
